// File: rtl/game_pkg.sv
// Shared definitions for the flappy-bird game sequencer.
// Contents: game state encoding, screen geometry, bird start position,
// BCD digit type and an MSD-first BCD magnitude compare.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_DYING   = 3'd3,
    ST_OVER    = 3'd4,
    ST_RESTART = 3'd5
  } game_state_e;

  localparam int SCREEN_ROWS = 480;
  localparam int SCREEN_COLS = 640;
  localparam int FLOOR_Y     = 432;
  localparam int WRAP_Y      = 480;
  localparam int BIRD_INI_X  = 160;
  localparam int BIRD_INI_Y  = 200;
  localparam int READY_TICKS = 64;
  localparam int DYING_TICKS = 32;

  localparam logic [11:0] SCORE_MAX = 12'h999;

  typedef logic [3:0] bcd_digit_t;

  // Returns 1 when a > b, comparing BCD digits from the hundreds down.
  function automatic logic bcd_gt(input logic [11:0] a, input logic [11:0] b);
    bcd_digit_t da;
    bcd_digit_t db;
    for (int i = 2; i >= 0; i--) begin
      da = a[i*4 +: 4];
      db = b[i*4 +: 4];
      if (da != db) return (da > db);
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle between the game sequencer and its surroundings (buttons,
// bird controller, pipe generator, display).
//   master : the sequencer (drives playing/fly/scroll_en/state/score)
//   slave  : the environment (drives tick, buttons, bird_y, collide, pipe_passed)
// Optional macro GAME_CTRL_HISCORE_EN adds the best-score signal.
interface game_ctrl_if;
  logic        tick;
  logic        btn_start;
  logic        btn_fly;
  logic [8:0]  bird_y;
  logic        collide;
  logic        pipe_passed;
  logic        playing;
  logic        fly;
  logic        scroll_en;
  logic [2:0]  state;
  logic [11:0] score;
`ifdef GAME_CTRL_HISCORE_EN
  logic [11:0] best;

  modport master (
    input  tick, btn_start, btn_fly, bird_y, collide, pipe_passed,
    output playing, fly, scroll_en, state, score, best
  );
  modport slave (
    output tick, btn_start, btn_fly, bird_y, collide, pipe_passed,
    input  playing, fly, scroll_en, state, score, best
  );
`else
  modport master (
    input  tick, btn_start, btn_fly, bird_y, collide, pipe_passed,
    output playing, fly, scroll_en, state, score
  );
  modport slave (
    output tick, btn_start, btn_fly, bird_y, collide, pipe_passed,
    input  playing, fly, scroll_en, state, score
  );
`endif
endinterface

// File: rtl/bcd_cnt3.sv
// Three-digit BCD score counter.
// Ports: clk, rst (sync, active-high), clr (sync clear), en (increment
// request), q (hundreds/tens/units). Saturates at SCORE_MAX and holds.
module bcd_cnt3 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  output logic [11:0] q
);
  import game_pkg::*;

  // Per-digit increment; a 9 wraps to 0 and carries into the next digit.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    bcd_digit_t d0;
    bcd_digit_t d1;
    bcd_digit_t d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (d0 != 4'd9) begin
      d0 = d0 + 4'd1;
    end else begin
      d0 = 4'd0;
      if (d1 != 4'd9) begin
        d1 = d1 + 4'd1;
      end else begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  function automatic logic at_max(input logic [11:0] v);
    return !bcd_gt(SCORE_MAX, v);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= 12'h000;
    end else if (en && !at_max(q)) begin
      q <= bcd_inc(q);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Top-level game sequencer: IDLE -> READY -> PLAY -> DYING -> OVER, with a
// RESTART sub-step that drops playing for one tick so the bird respawns.
// Ports: clk, rst (sync, active-high), bus (game_ctrl_if.master):
//   in : tick, btn_start, btn_fly, bird_y[8:0], collide, pipe_passed
//   out: playing, fly, scroll_en, state[2:0], score[11:0] (BCD)
// Optional macro GAME_CTRL_HISCORE_EN: adds bus.best, the highest score
// seen at OVER entry, cleared only by rst.
module game_ctrl #(
  parameter int FLOOR_Y     = 432,
  parameter int WRAP_Y      = 480,
  parameter int READY_TICKS = 64,
  parameter int DYING_TICKS = 32
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.master bus
);
  import game_pkg::*;

  localparam logic [8:0] FLOOR_Y9    = 9'(FLOOR_Y);
  localparam logic [8:0] WRAP_Y9     = 9'(WRAP_Y);
  localparam logic [7:0] READY_LAST  = 8'(READY_TICKS - 1);
  localparam logic [7:0] DYING_LAST  = 8'(DYING_TICKS - 1);

  game_state_e st;
  logic        playing_q;
  logic        scroll_q;
  logic        fly_req;
  logic [7:0]  tick_cnt;
  logic        btn_start_p0;
  logic        btn_fly_p0;
  logic [11:0] score_q;

  logic start_rise;
  logic fly_rise;
  logic on_floor;
  logic dead;
  logic score_clr;
  logic score_en;

  assign start_rise = bus.btn_start & ~btn_start_p0;
  assign fly_rise   = bus.btn_fly & ~btn_fly_p0;
  assign on_floor   = (bus.bird_y >= FLOOR_Y9);
  // The wrap test catches a bird that flew past row 0 and wrapped to 511-ish.
  assign dead       = bus.collide | on_floor | (bus.bird_y >= WRAP_Y9);

  assign score_clr  = start_rise && (st == ST_IDLE || st == ST_OVER);
  // Death wins over a pipe pass in the same cycle.
  assign score_en   = bus.pipe_passed && (st == ST_PLAY) && !dead;

  bcd_cnt3 u_score (
    .clk (clk),
    .rst (rst),
    .clr (score_clr),
    .en  (score_en),
    .q   (score_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= ST_IDLE;
      playing_q    <= 1'b0;
      scroll_q     <= 1'b0;
      fly_req      <= 1'b0;
      tick_cnt     <= 8'd0;
      btn_start_p0 <= 1'b0;
      btn_fly_p0   <= 1'b0;
    end else begin
      btn_start_p0 <= bus.btn_start;
      btn_fly_p0   <= bus.btn_fly;
      case (st)
        ST_IDLE: begin
          if (start_rise) begin
            st        <= ST_READY;
            playing_q <= 1'b1;
            tick_cnt  <= 8'd0;
          end
        end
        ST_READY: begin
          if (fly_rise) begin
            st       <= ST_PLAY;
            scroll_q <= 1'b1;
            tick_cnt <= 8'd0;
            fly_req  <= 1'b1;
          end else if (bus.tick) begin
            if (tick_cnt == READY_LAST) begin
              st       <= ST_PLAY;
              scroll_q <= 1'b1;
              tick_cnt <= 8'd0;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        ST_PLAY: begin
          if (dead) begin
            st       <= ST_DYING;
            scroll_q <= 1'b0;
            tick_cnt <= 8'd0;
            fly_req  <= 1'b0;
          end else if (fly_rise) begin
            fly_req <= 1'b1;
          end else if (bus.tick && fly_req) begin
            // Request has been seen by exactly one tick sample.
            fly_req <= 1'b0;
          end
        end
        ST_DYING: begin
          if (on_floor) begin
            st       <= ST_OVER;
            tick_cnt <= 8'd0;
          end else if (bus.tick) begin
            if (tick_cnt == DYING_LAST) begin
              st       <= ST_OVER;
              tick_cnt <= 8'd0;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        ST_OVER: begin
          if (start_rise) begin
            st        <= ST_RESTART;
            playing_q <= 1'b0;
            tick_cnt  <= 8'd0;
          end
        end
        ST_RESTART: begin
          // playing held low until the next frame tick so the bird resets.
          if (bus.tick) begin
            st        <= ST_READY;
            playing_q <= 1'b1;
            tick_cnt  <= 8'd0;
          end
        end
        default: begin
          st        <= ST_IDLE;
          playing_q <= 1'b0;
          scroll_q  <= 1'b0;
          fly_req   <= 1'b0;
          tick_cnt  <= 8'd0;
        end
      endcase
    end
  end

  assign bus.playing   = playing_q;
  assign bus.scroll_en = scroll_q;
  assign bus.state     = st;
  assign bus.score     = score_q;
  assign bus.fly       = fly_req & (st == ST_PLAY);

`ifdef GAME_CTRL_HISCORE_EN
  logic        enter_over;
  logic [11:0] best_q;

  assign enter_over = (st == ST_DYING) &&
                      (on_floor || (bus.tick && tick_cnt == DYING_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= 12'h000;
    end else if (enter_over && bcd_gt(score_q, best_q)) begin
      best_q <= score_q;
    end
  end

  assign bus.best = best_q;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_ctrl_if ifc ();

  game_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int errors = 0;
  int model_score = 0;

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    ifc.tick = 1'b1;
    step();
    ifc.tick = 1'b0;
  endtask

  task automatic pipe_pulse();
    ifc.pipe_passed = 1'b1;
    ifc.tick = 1'($urandom_range(0, 1));
    step();
    ifc.pipe_passed = 1'b0;
    ifc.tick = 1'b0;
    model_score = (model_score < 999) ? model_score + 1 : 999;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (ifc.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", ifc.state); end
    checks++; if (ifc.playing !== 1'b0) begin errors++; $display("FAIL reset_playing got %b exp 0", ifc.playing); end
    checks++; if (ifc.scroll_en !== 1'b0) begin errors++; $display("FAIL reset_scroll got %b exp 0", ifc.scroll_en); end
    checks++; if (ifc.fly !== 1'b0) begin errors++; $display("FAIL reset_fly got %b exp 0", ifc.fly); end
    checks++; if (ifc.score !== 12'h000) begin errors++; $display("FAIL reset_score got %h exp 000", ifc.score); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ready_to_play();
    ifc.btn_start = 1'b1;
    step();
    ifc.btn_start = 1'b0;
    checks++; if (ifc.state !== 3'd1) begin errors++; $display("FAIL start_state got %0d exp 1", ifc.state); end
    checks++; if (ifc.playing !== 1'b1) begin errors++; $display("FAIL start_playing got %b exp 1", ifc.playing); end
    checks++; if (ifc.scroll_en !== 1'b0) begin errors++; $display("FAIL start_scroll got %b exp 0", ifc.scroll_en); end
    checks++; if (ifc.score !== 12'h000) begin errors++; $display("FAIL start_score got %h exp 000", ifc.score); end
    for (int i = 0; i < 64; i++) begin
      repeat ($urandom_range(0, 2)) step();
      do_tick();
      checks++;
      if (ifc.state !== ((i == 63) ? 3'd2 : 3'd1)) begin
        errors++; $display("FAIL ready_count tick %0d got %0d exp %0d", i, ifc.state, (i == 63) ? 2 : 1);
      end
    end
    checks++; if (ifc.scroll_en !== 1'b1) begin errors++; $display("FAIL play_scroll got %b exp 1", ifc.scroll_en); end
    checks++; if (ifc.playing !== 1'b1) begin errors++; $display("FAIL play_playing got %b exp 1", ifc.playing); end
  endtask

  task automatic test_fly();
    int lead;
    for (int rep = 0; rep < 6; rep++) begin
      lead = $urandom_range(1, 4);
      ifc.btn_fly = 1'b1;
      ifc.tick = (rep % 2 == 1);
      step();
      ifc.btn_fly = 1'b0;
      ifc.tick = 1'b0;
      checks++; if (ifc.fly !== 1'b1) begin errors++; $display("FAIL fly_rise rep %0d got %b exp 1", rep, ifc.fly); end
      for (int k = 1; k < lead; k++) begin
        step();
        checks++; if (ifc.fly !== 1'b1) begin errors++; $display("FAIL fly_hold rep %0d got %b exp 1", rep, ifc.fly); end
      end
      do_tick();
      checks++; if (ifc.fly !== 1'b0) begin errors++; $display("FAIL fly_clear rep %0d got %b exp 0", rep, ifc.fly); end
      step();
      checks++; if (ifc.fly !== 1'b0) begin errors++; $display("FAIL fly_stay rep %0d got %b exp 0", rep, ifc.fly); end
    end
    checks++; if (ifc.state !== 3'd2) begin errors++; $display("FAIL fly_state got %0d exp 2", ifc.state); end
  endtask

  task automatic test_score();
    model_score = 0;
    for (int i = 0; i < 12; i++) begin
      pipe_pulse();
      checks++; if (ifc.score !== to_bcd(model_score)) begin errors++; $display("FAIL score_inc got %h exp %h", ifc.score, to_bcd(model_score)); end
      repeat ($urandom_range(0, 2)) step();
    end
    checks++; if (ifc.score !== 12'h012) begin errors++; $display("FAIL score_12 got %h exp 012", ifc.score); end
    while (model_score < 998) begin
      pipe_pulse();
      checks++; if (ifc.score !== to_bcd(model_score)) begin errors++; $display("FAIL score_run got %h exp %h", ifc.score, to_bcd(model_score)); end
      if ($urandom_range(0, 3) == 0) step();
    end
    for (int i = 0; i < 3; i++) begin
      pipe_pulse();
      checks++; if (ifc.score !== to_bcd(model_score)) begin errors++; $display("FAIL score_sat got %h exp %h", ifc.score, to_bcd(model_score)); end
    end
    checks++; if (ifc.score !== 12'h999) begin errors++; $display("FAIL score_999 got %h exp 999", ifc.score); end
  endtask

  task automatic test_death_collide();
    ifc.collide = 1'b1;
    ifc.pipe_passed = 1'b1;
    step();
    ifc.collide = 1'b0;
    ifc.pipe_passed = 1'b0;
    checks++; if (ifc.state !== 3'd3) begin errors++; $display("FAIL collide_state got %0d exp 3", ifc.state); end
    checks++; if (ifc.score !== to_bcd(model_score)) begin errors++; $display("FAIL collide_score got %h exp %h", ifc.score, to_bcd(model_score)); end
    checks++; if (ifc.scroll_en !== 1'b0) begin errors++; $display("FAIL dying_scroll got %b exp 0", ifc.scroll_en); end
    for (int i = 0; i < 32; i++) begin
      ifc.bird_y = 9'($urandom_range(0, 431));
      repeat ($urandom_range(0, 2)) step();
      do_tick();
      checks++;
      if (ifc.state !== ((i == 31) ? 3'd4 : 3'd3)) begin
        errors++; $display("FAIL dying_count tick %0d got %0d exp %0d", i, ifc.state, (i == 31) ? 4 : 3);
      end
    end
    ifc.bird_y = 9'd200;
    checks++; if (ifc.playing !== 1'b1) begin errors++; $display("FAIL over_playing got %b exp 1", ifc.playing); end
`ifdef GAME_CTRL_HISCORE_EN
    checks++; if (ifc.best !== 12'h999) begin errors++; $display("FAIL best_first got %h exp 999", ifc.best); end
`endif
  endtask

  task automatic restart_to_play();
    ifc.btn_start = 1'b1;
    step();
    ifc.btn_start = 1'b0;
    model_score = 0;
    checks++; if (ifc.state !== 3'd5) begin errors++; $display("FAIL restart_state got %0d exp 5", ifc.state); end
    checks++; if (ifc.playing !== 1'b0) begin errors++; $display("FAIL restart_playing got %b exp 0", ifc.playing); end
    checks++; if (ifc.score !== 12'h000) begin errors++; $display("FAIL restart_score got %h exp 000", ifc.score); end
    repeat ($urandom_range(1, 3)) begin
      step();
      checks++; if (ifc.playing !== 1'b0) begin errors++; $display("FAIL restart_hold got %b exp 0", ifc.playing); end
    end
    do_tick();
    checks++; if (ifc.state !== 3'd1) begin errors++; $display("FAIL reready_state got %0d exp 1", ifc.state); end
    checks++; if (ifc.playing !== 1'b1) begin errors++; $display("FAIL reready_playing got %b exp 1", ifc.playing); end
    checks++; if (ifc.fly !== 1'b0) begin errors++; $display("FAIL ready_fly got %b exp 0", ifc.fly); end
    ifc.btn_fly = 1'b1;
    step();
    ifc.btn_fly = 1'b0;
    checks++; if (ifc.state !== 3'd2) begin errors++; $display("FAIL flyjump_state got %0d exp 2", ifc.state); end
    checks++; if (ifc.fly !== 1'b1) begin errors++; $display("FAIL flyjump_fly got %b exp 1", ifc.fly); end
  endtask

  task automatic test_floor_and_wrap(input logic [8:0] y, input string nm);
    restart_to_play();
    repeat ($urandom_range(1, 5)) begin
      pipe_pulse();
    end
    checks++; if (ifc.score !== to_bcd(model_score)) begin errors++; $display("FAIL %s_score got %h exp %h", nm, ifc.score, to_bcd(model_score)); end
    ifc.bird_y = y;
    step();
    checks++; if (ifc.state !== 3'd3) begin errors++; $display("FAIL %s_dying got %0d exp 3", nm, ifc.state); end
    checks++; if (ifc.fly !== 1'b0) begin errors++; $display("FAIL %s_fly got %b exp 0", nm, ifc.fly); end
    step();
    checks++; if (ifc.state !== 3'd4) begin errors++; $display("FAIL %s_over got %0d exp 4", nm, ifc.state); end
    ifc.bird_y = 9'd200;
`ifdef GAME_CTRL_HISCORE_EN
    checks++; if (ifc.best !== 12'h999) begin errors++; $display("FAIL %s_best got %h exp 999", nm, ifc.best); end
`endif
  endtask

  task automatic test_reset_midgame();
    restart_to_play();
    pipe_pulse();
    pipe_pulse();
    checks++; if (ifc.score !== to_bcd(model_score)) begin errors++; $display("FAIL mid_score got %h exp %h", ifc.score, to_bcd(model_score)); end
    rst = 1'b1;
    step();
    checks++; if (ifc.state !== 3'd0) begin errors++; $display("FAIL mid_rst_state got %0d exp 0", ifc.state); end
    checks++; if (ifc.fly !== 1'b0) begin errors++; $display("FAIL mid_rst_fly got %b exp 0", ifc.fly); end
    checks++; if (ifc.score !== 12'h000) begin errors++; $display("FAIL mid_rst_score got %h exp 000", ifc.score); end
    checks++; if (ifc.playing !== 1'b0) begin errors++; $display("FAIL mid_rst_playing got %b exp 0", ifc.playing); end
    checks++; if (ifc.scroll_en !== 1'b0) begin errors++; $display("FAIL mid_rst_scroll got %b exp 0", ifc.scroll_en); end
`ifdef GAME_CTRL_HISCORE_EN
    checks++; if (ifc.best !== 12'h000) begin errors++; $display("FAIL mid_rst_best got %h exp 000", ifc.best); end
`endif
    rst = 1'b0;
    step();
  endtask

  initial begin
    ifc.tick        = 1'b0;
    ifc.btn_start   = 1'b0;
    ifc.btn_fly     = 1'b0;
    ifc.bird_y      = 9'd200;
    ifc.collide     = 1'b0;
    ifc.pipe_passed = 1'b0;
    test_reset();
    test_ready_to_play();
    test_fly();
    test_score();
    test_death_collide();
    test_floor_and_wrap(9'd432, "floor");
    test_floor_and_wrap(9'd500, "wrap");
    test_reset_midgame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
